sw_traceback: RTL
=================

Name: sw_traceback

Overview:
- Consumer-side partner of the banded Smith-Waterman PE array: the PE array writes one direction word per cell; this block reads the words back and walks from the max-score cell to the local-alignment start.
- Emits the alignment as a reverse-order stream of edit ops (match, mismatch, insertion, deletion) on a valid/ready interface.
- Sits between the direction-pointer RAM and the alignment output formatter.

Parameters:
- MAX_LEN, 64, maximum query and reference length in symbols.
- AW, $clog2(MAX_LEN+1), coordinate width.
- LW, $clog2(2*MAX_LEN+1), alignment-length counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  single-cycle pulse that begins a traceback; ignored while busy=1.
- i_end  in  AW  query end coordinate, 1-based.
- j_end  in  AW  reference end coordinate, 1-based.
- dir_rd_en  out  1  direction RAM read strobe.
- dir_i  out  AW  read address, row.
- dir_j  out  AW  read address, column.
- dir_data  in  5  read data, valid exactly 1 cycle after dir_rd_en. Bits: [1:0] h_src (00 zero/local start, 01 diag, 10 from I, 11 from D); [2] i_ext (I came from I extension); [3] d_ext (D came from D extension); [4] match (q==r).
- op_valid  out  1  op available.
- op_ready  in  1  downstream accepts.
- op_code  out  2  00 MATCH, 01 MISMATCH, 10 INS (j-1), 11 DEL (i-1).
- busy  out  1  traceback in progress.
- done  out  1  one-cycle pulse at completion.
- aln_len  out  LW  number of ops emitted; valid with done, held until next start.
- i_start  out  AW  final i coordinate; valid with done.
- j_start  out  AW  final j coordinate; valid with done.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, gap state H. Reset asserted mid-walk aborts immediately; no done pulse.
- FSM states: IDLE, READ, EVAL, EMIT, FIN.
  - IDLE, start=1:
    - Latch i_end/j_end into cur_i/cur_j; clear aln_len; gap state = H; busy=1.
    - If i_end==0 or j_end==0, go to FIN (aln_len=0).
    - Otherwise go to READ.
  - READ: dir_rd_en=1 for one cycle with dir_i=cur_i, dir_j=cur_j; go to EVAL. Capture dir_data into a word register on entering EVAL.
  - EVAL, by gap state, using the registered word (no re-read):
    - Gap H, h_src=00: go to FIN, no op.
    - Gap H, h_src=01: op = match ? MATCH : MISMATCH; decrement both i and j; go to EMIT.
    - Gap H, h_src=10: switch gap state to I, stay in EVAL one more cycle.
    - Gap H, h_src=11: switch gap state to D, stay in EVAL one more cycle.
    - Gap I: op = INS; j-1; next gap state = i_ext ? I : H; go to EMIT.
    - Gap D: op = DEL; i-1; next gap state = d_ext ? D : H; go to EMIT.
  - EMIT:
    - op_valid=1 with op_code held stable until op_valid && op_ready. op_valid is never dropped before acceptance.
    - On acceptance, aln_len+1. Then go to FIN if the updated cur_i==0 or cur_j==0, else go to READ.
  - FIN: done=1 for one cycle; i_start/j_start = cur_i/cur_j; busy=0; go to IDLE.
- Minimum of 3 cycles per op with op_ready tied high.
- Arithmetic: coordinates unsigned; no decrement below 0 (the boundary check precedes the move). aln_len saturates at 2*MAX_LEN.
- Simultaneous events:
  - start in the FIN cycle is ignored.
  - start in the same cycle as done is ignored.
  - A start in the first IDLE cycle afterwards is accepted.
- A word with h_src=00 read in gap state I or D is illegal. The gap bits still govern; the bench flags the violation with an assertion.

Decomposition:
- Shared package sw_pkg:
  - Op codes OP_MATCH, OP_MISMATCH, OP_INS, OP_DEL.
  - h_src encodings HSRC_ZERO, HSRC_DIAG, HSRC_I, HSRC_D.
  - Direction-word bit positions.
  - Gap-state enum.
- Single flat module; no sub-module needed. The direction RAM lives outside.

Test Plan:
- Pure diagonal: start (3,3); cells (3,3),(2,2),(1,1) are h_src=01, match=1 -> ops MATCH x3, done with aln_len=3, i_start=0, j_start=0.
- Affine insertion: (4,4) h_src=10, i_ext=1; (4,3) i_ext=0; (4,2) h_src=00 -> INS, INS, then FIN; aln_len=2; start coords (4,2).
- Deletion then mismatch: (5,2) h_src=11, d_ext=0; (4,2) h_src=01, match=0; (3,1) h_src=00 -> DEL, MISMATCH; aln_len=2; start coords (3,1).
- Backpressure: op_ready low for 5 cycles during the first op -> op_valid/op_code stable throughout, no extra dir_rd_en, aln_len unchanged until acceptance.
- Edge/ignored start: start with i_end=0 -> done next cycle, aln_len=0, no dir_rd_en; start pulsed while busy -> no effect on cur_i/cur_j.
- Reset mid-walk: rst_n low during EMIT -> op_valid=0, busy=0, done never pulses; next start runs cleanly.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman traceback path: op codes,
// direction-word layout, gap state and traceback FSM states.
package sw_pkg;

  typedef enum logic [1:0] {
    OP_MATCH    = 2'b00,
    OP_MISMATCH = 2'b01,
    OP_INS      = 2'b10,
    OP_DEL      = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    HSRC_ZERO = 2'b00,
    HSRC_DIAG = 2'b01,
    HSRC_I    = 2'b10,
    HSRC_D    = 2'b11
  } hsrc_e;

  // Direction-word bit positions
  localparam int unsigned DW_W     = 5;
  localparam int unsigned DW_HSRC  = 0;  // [1:0]
  localparam int unsigned DW_IEXT  = 2;
  localparam int unsigned DW_DEXT  = 3;
  localparam int unsigned DW_MATCH = 4;

  typedef enum logic [1:0] {
    GAP_H = 2'd0,
    GAP_I = 2'd1,
    GAP_D = 2'd2
  } gap_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EVAL = 3'd2,
    ST_EMIT = 3'd3,
    ST_FIN  = 3'd4
  } state_e;

endpackage

// File: rtl/sw_traceback_if.sv
// Edit-op output stream (valid/ready) from the traceback walker.
interface sw_traceback_if
  import sw_pkg::*;
  ();
  logic op_valid;
  logic op_ready;
  op_e  op_code;

  modport master (output op_valid, output op_code, input  op_ready);
  modport slave  (input  op_valid, input  op_code, output op_ready);
endinterface

// File: rtl/sw_traceback.sv
// Smith-Waterman traceback walker: reads direction words from the max-score
// cell back to the local-alignment start and streams edit ops in reverse.
module sw_traceback
  import sw_pkg::*;
#(
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned AW      = $clog2(MAX_LEN + 1),
  parameter int unsigned LW      = $clog2(2 * MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [AW-1:0]        i_end,
  input  logic [AW-1:0]        j_end,
  output logic                 dir_rd_en,
  output logic [AW-1:0]        dir_i,
  output logic [AW-1:0]        dir_j,
  input  logic [DW_W-1:0]      dir_data,
  sw_traceback_if.master       op,
  output logic                 busy,
  output logic                 done,
  output logic [LW-1:0]        aln_len,
  output logic [AW-1:0]        i_start,
  output logic [AW-1:0]        j_start
);

  localparam logic [LW-1:0] LEN_MAX = LW'(2 * MAX_LEN);

  state_e          r_state, w_state_nxt;
  gap_e            r_gap, w_gap_nxt;
  op_e             r_op, w_op_nxt;
  logic [AW-1:0]   r_cur_i, r_cur_j, w_cur_i_nxt, w_cur_j_nxt;
  logic [LW-1:0]   r_aln_len, w_aln_nxt;
  logic [AW-1:0]   r_i_start, r_j_start;
  logic [DW_W-1:0] r_word, w_word;
  logic            r_rd_q;

  function automatic logic [AW-1:0] dec_sat(input logic [AW-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  // RAM data arrives the cycle after the strobe; the first EVAL cycle uses it
  // directly and the registered copy serves the extra gap-switch EVAL cycle.
  assign w_word = r_rd_q ? dir_data : r_word;

  // Next-state, coordinate, gap-state and op selection
  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    w_op_nxt    = r_op;
    w_cur_i_nxt = r_cur_i;
    w_cur_j_nxt = r_cur_j;
    w_aln_nxt   = r_aln_len;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_cur_i_nxt = i_end;
          w_cur_j_nxt = j_end;
          w_aln_nxt   = '0;
          w_gap_nxt   = GAP_H;
          w_state_nxt = (i_end == '0 || j_end == '0) ? ST_FIN : ST_READ;
        end
      end
      ST_READ: w_state_nxt = ST_EVAL;
      ST_EVAL: begin
        unique case (r_gap)
          GAP_H: begin
            unique case (hsrc_e'(w_word[DW_HSRC +: 2]))
              HSRC_ZERO: w_state_nxt = ST_FIN;
              HSRC_DIAG: begin
                w_op_nxt    = w_word[DW_MATCH] ? OP_MATCH : OP_MISMATCH;
                w_cur_i_nxt = dec_sat(r_cur_i);
                w_cur_j_nxt = dec_sat(r_cur_j);
                w_state_nxt = ST_EMIT;
              end
              HSRC_I: w_gap_nxt = GAP_I;
              HSRC_D: w_gap_nxt = GAP_D;
              default: w_state_nxt = ST_FIN;
            endcase
          end
          GAP_I: begin
            w_op_nxt    = OP_INS;
            w_cur_j_nxt = dec_sat(r_cur_j);
            w_gap_nxt   = w_word[DW_IEXT] ? GAP_I : GAP_H;
            w_state_nxt = ST_EMIT;
          end
          GAP_D: begin
            w_op_nxt    = OP_DEL;
            w_cur_i_nxt = dec_sat(r_cur_i);
            w_gap_nxt   = w_word[DW_DEXT] ? GAP_D : GAP_H;
            w_state_nxt = ST_EMIT;
          end
          default: w_gap_nxt = GAP_H;
        endcase
      end
      ST_EMIT: begin
        if (op.op_ready) begin
          w_aln_nxt   = (r_aln_len == LEN_MAX) ? r_aln_len : r_aln_len + 1'b1;
          w_state_nxt = (r_cur_i == '0 || r_cur_j == '0) ? ST_FIN : ST_READ;
        end
      end
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, walk registers and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_gap     <= GAP_H;
      r_op      <= OP_MATCH;
      r_cur_i   <= '0;
      r_cur_j   <= '0;
      r_aln_len <= '0;
      r_i_start <= '0;
      r_j_start <= '0;
      r_word    <= '0;
      r_rd_q    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gap     <= w_gap_nxt;
      r_op      <= w_op_nxt;
      r_cur_i   <= w_cur_i_nxt;
      r_cur_j   <= w_cur_j_nxt;
      r_aln_len <= w_aln_nxt;
      r_rd_q    <= (r_state == ST_READ);
      if (r_rd_q) r_word <= dir_data;
      if (w_state_nxt == ST_FIN) begin
        r_i_start <= w_cur_i_nxt;
        r_j_start <= w_cur_j_nxt;
      end
    end
  end

  assign dir_rd_en   = (r_state == ST_READ);
  assign dir_i       = r_cur_i;
  assign dir_j       = r_cur_j;
  assign op.op_valid = (r_state == ST_EMIT);
  assign op.op_code  = r_op;
  assign busy        = (r_state == ST_READ) || (r_state == ST_EVAL) || (r_state == ST_EMIT);
  assign done        = (r_state == ST_FIN);
  assign aln_len     = r_aln_len;
  assign i_start     = r_i_start;
  assign j_start     = r_j_start;

endmodule
